seq_scan_ctrl: RTL and testbench
================================

// Module: seq_scan_ctrl
// PURPOSE
//  Controller that owns a programmable serial pattern detector. Accepts parallel words over a
//  valid/ready handshake and serialises them MSB-first into the detector, one bit per clock.
//  Counts pattern hits and reports per-word completion. Pattern and length are software-configurable.
//  Reset pattern is 4'b1011. Sits between the host word bus and the serial detection datapath.
// PARAMETERS
//  WORD_W   8   bits per input word, shifted MSB-first
//  PAT_MAX  8   maximum pattern length in bits
//  CNT_W    8   width of the saturating match counter
// PORTS
//  clk          in   1                  single clock; all flops on posedge
//  rst          in   1                  reset, asynchronous, active-high
//  cfg_load     in   1                  load cfg_pattern/cfg_len; honoured only in IDLE
//  cfg_pattern  in   PAT_MAX            pattern; bit [cfg_len-1] is the oldest bit
//  cfg_len      in   clog2(PAT_MAX+1)   pattern length, 0..PAT_MAX
//  clear        in   1                  zero the match count and the detector history (any state)
//  in_valid     in   1                  input word valid
//  in_ready     out  1                  high only in IDLE
//  in_data      in   WORD_W             input word
//  busy         out  1                  high in SHIFT and DONE
//  match_pulse  out  1                  registered 1-cycle pulse, one cycle after a matching bit
//  match_count  out  CNT_W              saturating total of matches
//  word_done    out  1                  1-cycle pulse in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, pattern=4'b1011, len=4, history=0, hist_cnt=0, bit_idx=0.
//    Outputs at reset: match_count=0, match_pulse=0, word_done=0, busy=0, in_ready=1.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: a transfer occurs when in_valid & in_ready.
//    On transfer: capture in_data into the shift register, bit_idx=0, go to SHIFT.
//  SHIFT: each cycle, push shreg MSB into history (shift left); increment hist_cnt (saturates at PAT_MAX).
//    After WORD_W bits, go to DONE.
//  DONE: word_done=1 for one cycle, then IDLE.
//    Word accepted at edge 0; bits shifted on edges 1..WORD_W; word_done high during cycle WORD_W+1.
//    Next word can be accepted at edge WORD_W+2.
//  Match rule: match when the low cfg_len bits of the new history equal cfg_pattern[len-1:0] and hist_cnt >= len.
//    Overlapping matches count. Detection is continuous across word boundaries.
//  len=0 never matches. Values above PAT_MAX are clamped to PAT_MAX.
//  match_count increments on each match and holds at 2^CNT_W-1.
//  Boundary cases:
//    clear and a transfer in the same IDLE cycle: clear wins; the word is not accepted.
//    clear during SHIFT: count and history zeroed; the remaining bits shift into the cleared history.
//      A match on that same cycle is discarded.
//    cfg_load outside IDLE: ignored; no effect on the word in flight.
//    cfg_load in IDLE: takes effect on the next shifted bit; history is kept.
//    rst mid-word: immediate abort; the partial word is lost; all reset values apply.
// CONFIGURATION
//  SEQ_IRQ_EN defined:
//    Adds port irq_thresh (in, CNT_W) and port irq (out, 1).
//    irq is a sticky register, set on the cycle match_count reaches or passes irq_thresh (irq_thresh != 0).
//    irq is cleared by clear or rst.
//  SEQ_IRQ_EN undefined: neither port exists; no threshold logic.
// STRUCTURE
//  Package seq_scan_pkg: FSM state enum (IDLE/SHIFT/DONE), RST_PATTERN=8'b0000_1011, RST_LEN=4.
//  Sub-module seq_shift_matcher:
//    Holds the history register, hist_cnt and the compare.
//    Inputs: bit_in, shift_en, clear, pattern, len. Output: match (combinational).
//  Top level: FSM, word shift register, bit counter, counter/pulse registers, optional irq.
// TESTING
//  1. Reset, then no stimulus -> in_ready=1, busy=0, match_count=0, match_pulse=0.
//  2. Default pattern, word 8'b1011_1011 -> match_pulse after bits 4 and 8; match_count=2.
//     word_done pulses during cycle 9 after acceptance.
//  3. Load pattern 3'b101 (len 3), word 8'b1010_1000 -> matches at bits 3 and 5; match_count=2.
//  4. Default pattern, word 8'h05 then 8'h80 -> one match, on bit 1 of the second word (cross-word).
//  5. CNT_W=2, default pattern, four words 8'hBB -> match_count saturates at 3.
//     Then clear -> match_count=0.
//  6. cfg_load during SHIFT ignored; clear with in_valid in IDLE -> word refused.
//     rst during SHIFT -> immediate IDLE.
//     With SEQ_IRQ_EN and irq_thresh=2, test 2 sets irq at the second match.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and reset constants for the serial pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] RST_PATTERN = 8'b0000_1011;
  localparam int         RST_LEN     = 4;

endpackage

// File: rtl/seq_shift_matcher.sv
// Serial history register with fill counter and a length-masked pattern compare.
module seq_shift_matcher #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               shift_en,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);
  import seq_scan_pkg::*;

  logic [PAT_MAX-1:0] history_reg;
  logic [PAT_MAX-1:0] history_next;
  logic [LEN_W-1:0]   hist_cnt_reg;
  logic [LEN_W-1:0]   hist_cnt_next;
  logic [PAT_MAX-1:0] len_mask;

  // Only the low len bits take part in the compare.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_MAX; gi++) begin : g_mask
      assign len_mask[gi] = (len > LEN_W'(gi));
    end
  endgenerate

  assign history_next  = {history_reg[PAT_MAX-2:0], bit_in};
  assign hist_cnt_next = (hist_cnt_reg == LEN_W'(PAT_MAX)) ? hist_cnt_reg
                                                           : hist_cnt_reg + LEN_W'(1);

  assign match = shift_en && (len != '0) && (hist_cnt_next >= len) &&
                 ((history_next & len_mask) == (pattern & len_mask));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_reg  <= '0;
      hist_cnt_reg <= '0;
    end else if (clear) begin
      history_reg  <= '0;
      hist_cnt_reg <= '0;
    end else if (shift_en) begin
      history_reg  <= history_next;
      hist_cnt_reg <= hist_cnt_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-serial scan controller feeding a programmable pattern detector with a saturating hit count.
// Optional sticky threshold interrupt (irq_thresh/irq) is built when SEQ_IRQ_EN is defined.
module seq_scan_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(PAT_MAX + 1),
  localparam int BIT_W  = $clog2(WORD_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               word_done
`ifdef SEQ_IRQ_EN
  ,
  input  logic [CNT_W-1:0]   irq_thresh,
  output logic               irq
`endif
);
  import seq_scan_pkg::*;

  state_t             state_reg, state_next;
  logic [WORD_W-1:0]  shreg_reg;
  logic [BIT_W-1:0]   bit_idx_reg;
  logic [PAT_MAX-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               pulse_reg;
  logic               accept;
  logic               shift_en;
  logic               match;
  logic               hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // A clear in IDLE drops ready so a word is never half-accepted.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    word_done  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = !clear;
        if (in_valid && !clear) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (bit_idx_reg == BIT_W'(WORD_W - 1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        word_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign shift_en    = (state_reg == SHIFT);
  assign len_clamped = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg   <= '0;
      bit_idx_reg <= '0;
      pattern_reg <= PAT_MAX'(RST_PATTERN);
      len_reg     <= LEN_W'(RST_LEN);
    end else begin
      if (accept) begin
        shreg_reg   <= in_data;
        bit_idx_reg <= '0;
      end else if (shift_en) begin
        shreg_reg   <= shreg_reg << 1;
        bit_idx_reg <= bit_idx_reg + BIT_W'(1);
      end
      if (cfg_load && state_reg == IDLE) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= len_clamped;
      end
    end
  end

  seq_shift_matcher #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (shreg_reg[WORD_W-1]),
    .shift_en (shift_en),
    .clear    (clear),
    .pattern  (pattern_reg),
    .len      (len_reg),
    .match    (match)
  );

  // A match coinciding with clear is discarded along with the history.
  assign hit = match && !clear;

  always_comb begin
    count_next = count_reg;
    if (clear)                          count_next = '0;
    else if (hit && count_reg != '1)    count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      pulse_reg <= hit;
    end
  end

  assign match_count = count_reg;
  assign match_pulse = pulse_reg;

`ifdef SEQ_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        irq_reg <= 1'b0;
    else if (clear) irq_reg <= 1'b0;
    else if (irq_thresh != '0 && count_next >= irq_thresh) irq_reg <= 1'b1;
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed, table-driven bench for seq_scan_ctrl, plus a narrow-counter instance for saturation.
module tb_seq_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cfg_load, clear, in_valid;
  logic [7:0] cfg_pattern, in_data;
  logic [3:0] cfg_len;
  logic       in_ready, busy, match_pulse, word_done;
  logic [7:0] match_count;
  logic       s_in_ready, s_busy, s_match_pulse, s_word_done;
  logic [1:0] s_match_count;
`ifdef SEQ_IRQ_EN
  logic [7:0] irq_thresh;
  logic       irq;
  logic [1:0] s_irq_thresh;
  logic       s_irq;
`endif

  int asserts = 0;
  int fails   = 0;

  seq_scan_ctrl dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .busy(busy),
    .match_pulse(match_pulse), .match_count(match_count), .word_done(word_done)
`ifdef SEQ_IRQ_EN
    , .irq_thresh(irq_thresh), .irq(irq)
`endif
  );

  seq_scan_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .busy(s_busy),
    .match_pulse(s_match_pulse), .match_count(s_match_count), .word_done(s_word_done)
`ifdef SEQ_IRQ_EN
    , .irq_thresh(s_irq_thresh), .irq(s_irq)
`endif
  );

  typedef struct {
    bit         do_clear;
    bit         do_load;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] word;
    logic [7:0] exp_mask;   // bit k-1 set = match_pulse seen for shifted bit k
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] pat, input logic [3:0] len);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_load    = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  // act_kind: 0 none, 1 cfg_load, 2 clear; asserted for one cycle after edge act_at.
  task automatic run_word(input logic [7:0] w, input int act_at, input int act_kind,
                          output logic [7:0] mask);
    mask     = '0;
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("shift_not_ready", in_ready, 0);
    for (int k = 1; k <= 8; k++) begin
      if (act_at == k - 1) begin
        if (act_kind == 1) cfg_load = 1'b1;
        if (act_kind == 2) clear = 1'b1;
      end
      @(posedge clk); #1;
      cfg_load = 1'b0;
      clear    = 1'b0;
      mask[k-1] = match_pulse;
      if (k == 7) check("word_done_early", word_done, 0);
    end
    check("word_done_pulse", word_done, 1);
    @(posedge clk); #1;
    check("word_done_end", word_done, 0);
    check("ready_after", in_ready, 1);
    $display("word %02h: mask %08b count %0d small_count %0d", w, mask, match_count, s_match_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    rst = 1'b1; cfg_load = 1'b0; clear = 1'b0; in_valid = 1'b0;
    cfg_pattern = '0; cfg_len = '0; in_data = '0;
`ifdef SEQ_IRQ_EN
    irq_thresh = 8'd2;
    s_irq_thresh = 2'd0;
`endif

    vecs[0] = '{0, 0, 8'h00, 4'd0, 8'hBB, 8'b1000_1000, 8'd2};  // reset pattern 1011
    vecs[1] = '{1, 1, 8'h05, 4'd3, 8'hA8, 8'b0001_0100, 8'd2};  // 101, overlapping
    vecs[2] = '{1, 1, 8'h0B, 4'd4, 8'h05, 8'b0000_0000, 8'd0};
    vecs[3] = '{0, 0, 8'h00, 4'd0, 8'h80, 8'b0000_0001, 8'd1};  // cross-word hit
    vecs[4] = '{1, 1, 8'h00, 4'd0, 8'h00, 8'b0000_0000, 8'd0};  // len 0 never matches
    vecs[5] = '{1, 1, 8'hFF, 4'd15, 8'hFF, 8'b1000_0000, 8'd1}; // len clamped to 8
    vecs[6] = '{0, 0, 8'h00, 4'd0, 8'hFF, 8'b1111_1111, 8'd9};
    vecs[7] = '{0, 0, 8'h00, 4'd0, 8'h7F, 8'b0000_0000, 8'd9};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", match_count, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_word_done", word_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("small_idle", {s_in_ready, s_busy, s_word_done, s_match_pulse, s_match_count}, 6'b100000);

    foreach (vecs[i]) begin
      if (vecs[i].do_clear) do_clear();
      if (vecs[i].do_load)  do_load(vecs[i].pat, vecs[i].len);
      run_word(vecs[i].word, -1, 0, m);
      check($sformatf("vec%0d_mask", i), m, vecs[i].exp_mask);
      check($sformatf("vec%0d_count", i), match_count, vecs[i].exp_count);
    end

    // Saturation on the 2-bit counter instance.
    do_clear();
    do_load(8'h0B, 4'd4);
    for (int w = 0; w < 4; w++) begin
      run_word(8'hBB, -1, 0, m);
      check($sformatf("sat_small_%0d", w), s_match_count, (w == 0) ? 2 : 3);
    end
    check("sat_main", match_count, 8);
    do_clear();
    check("sat_clear_small", s_match_count, 0);
    check("sat_clear_main", match_count, 0);

    // cfg_load while shifting must not disturb the word or the stored pattern.
    cfg_pattern = 8'h05; cfg_len = 4'd3;
    run_word(8'hBB, 1, 1, m);
    check("midload_mask", m, 8'b1000_1000);
    check("midload_count", match_count, 2);
    do_clear();
    run_word(8'hA8, -1, 0, m);
    check("midload_kept_mask", m, 8'b0000_0000);

    // Clear during SHIFT: bit-4 hit discarded, bits 5..8 refill the history.
    do_clear();
    run_word(8'hBB, 3, 2, m);
    check("midclear_mask", m, 8'b1000_0000);
    check("midclear_count", match_count, 1);

    // Clear and valid together in IDLE: word refused.
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hBB;
    #1;
    check("clr_valid_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_valid_busy", busy, 0);
    check("clr_valid_count", match_count, 0);
    @(posedge clk); #1;
    check("clr_valid_still_idle", busy, 0);
    $display("clear+valid in IDLE: busy %0b count %0d", busy, match_count);

    // Async reset mid-word, then confirm the reset pattern is back.
    do_load(8'h05, 4'd3);
    in_data = 8'hBB; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_count", match_count, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_count", match_count, 0);
    check("rst_mid_pulse", match_pulse, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_word(8'hBB, -1, 0, m);
    check("post_rst_mask", m, 8'b1000_1000);
    check("post_rst_count", match_count, 2);

`ifdef SEQ_IRQ_EN
    do_clear();
    check("irq_cleared", irq, 0);
    run_word(8'h0B, -1, 0, m);
    check("irq_below", irq, 0);
    run_word(8'hBB, -1, 0, m);
    check("irq_set", irq, 1);
    check("irq_small_off", s_irq, 0);
    do_clear();
    check("irq_clear", irq, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
